// File: rtl/revo_trigger_encoder_if.sv
// Signal bundle between the trigger encoder and its environment.
// The master drives the raw trigger lines; the slave is the encoder.
`timescale 1ns/1ps
interface revo_trigger_encoder_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0] raw_trg;
    logic                fake_enable;
    logic [CHANNELS-1:0] trg_out;
    logic                encoded_ce;
    logic                frame_busy;
    logic                overflow;
    logic                revo_fake;

    modport master (
        output raw_trg, fake_enable,
        input  trg_out, encoded_ce, frame_busy, overflow, revo_fake
    );

    modport slave (
        input  raw_trg, fake_enable,
        output trg_out, encoded_ce, frame_busy, overflow, revo_fake
    );
endinterface

// File: rtl/revo_trigger_encoder.sv
// Multi-channel trigger qualifier and serialiser onto an ODDR clock-enable line,
// with a synthesised channel-0 revolution marker when the real one goes missing.
`timescale 1ns/1ps
module revo_trigger_encoder #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned HISTORY      = 16,
    parameter int unsigned MAX_DURATION = 8,
    parameter int unsigned GAP          = 2,
    parameter int unsigned REVO_PERIOD  = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    revo_trigger_encoder_if.slave        bus
);
    localparam int unsigned CH_BITS = $clog2(CHANNELS);
    localparam int unsigned SEQ_MAX = (CH_BITS > GAP) ? CH_BITS : GAP;
    localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int unsigned PER_W   = $clog2(REVO_PERIOD);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(REVO_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_CHAN, S_GAP} state_t;

    logic [HISTORY-1:0]  r_hist [CHANNELS];
    logic [CHANNELS-1:0] r_trg_out, r_pend;
    logic                r_ce, r_busy, r_overflow, r_revo_fake, r_armed;
    logic [PER_W-1:0]    r_period;
    state_t              r_state;
    logic [SEQ_W-1:0]    r_seq;
    logic [CH_BITS-1:0]  r_shift;

    logic [CHANNELS-1:0] w_qual, w_trg, w_clr;
    logic                w_fake, w_ovf, w_ce_nx, w_busy_nx;
    state_t              w_state_nx;
    logic [SEQ_W-1:0]    w_seq_nx;
    logic [CH_BITS-1:0]  w_shift_nx, w_sel;

    // Short isolated pulse: leading edge at the window boundary, quiet before, not full width.
    always_comb begin
        w_qual = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            w_qual[c] = r_hist[c][MAX_DURATION-1]
                     && (r_hist[c][HISTORY-1:MAX_DURATION] == '0)
                     && !(&r_hist[c][MAX_DURATION-1:0]);
        end
    end

    // Fake ch0 only fires when the period expires without a real ch0 this cycle.
    always_comb begin
        w_fake   = r_armed && bus.fake_enable && (r_period == PER_LAST) && !w_qual[0];
        w_trg    = w_qual;
        w_trg[0] = w_qual[0] | w_fake;
        w_ovf    = |(w_trg & r_pend & ~w_clr);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < int'(CHANNELS); c++) r_hist[c] <= '0;
        end else begin
            for (int c = 0; c < int'(CHANNELS); c++)
                r_hist[c] <= {r_hist[c][HISTORY-2:0], bus.raw_trg[c]};
        end
    end

    // Frame sequencer: pick lowest pending channel, emit start, index bits, gap.
    always_comb begin
        w_state_nx = r_state;
        w_seq_nx   = r_seq;
        w_shift_nx = r_shift;
        w_ce_nx    = 1'b1;
        w_busy_nx  = 1'b0;
        w_clr      = '0;
        w_sel      = '0;
        for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
            if (r_pend[c]) w_sel = CH_BITS'(c);
        end
        case (r_state)
            S_IDLE: begin
                if (|r_pend) begin
                    w_clr[w_sel] = 1'b1;
                    w_shift_nx   = w_sel;
                    w_state_nx   = S_START;
                    w_ce_nx      = 1'b0;
                    w_busy_nx    = 1'b1;
                end
            end
            S_START: begin
                w_state_nx = S_CHAN;
                w_seq_nx   = '0;
                w_ce_nx    = ~r_shift[CH_BITS-1];
                w_shift_nx = r_shift << 1;
                w_busy_nx  = 1'b1;
            end
            S_CHAN: begin
                w_busy_nx = 1'b1;
                if (r_seq == SEQ_W'(CH_BITS - 1)) begin
                    w_state_nx = S_GAP;
                    w_seq_nx   = '0;
                end else begin
                    w_seq_nx   = r_seq + SEQ_W'(1);
                    w_ce_nx    = ~r_shift[CH_BITS-1];
                    w_shift_nx = r_shift << 1;
                end
            end
            S_GAP: begin
                if (r_seq == SEQ_W'(GAP - 1)) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_seq_nx  = r_seq + SEQ_W'(1);
                    w_busy_nx = 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_seq       <= '0;
            r_shift     <= '0;
            r_ce        <= 1'b1;
            r_busy      <= 1'b0;
            r_trg_out   <= '0;
            r_pend      <= '0;
            r_overflow  <= 1'b0;
            r_revo_fake <= 1'b0;
            r_armed     <= 1'b0;
            r_period    <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_seq      <= w_seq_nx;
            r_shift    <= w_shift_nx;
            r_ce       <= w_ce_nx;
            r_busy     <= w_busy_nx;
            r_trg_out  <= w_trg;
            r_pend     <= (r_pend & ~w_clr) | w_trg;
            r_overflow <= r_overflow | w_ovf;
            r_armed    <= r_armed | w_qual[0];
            if (w_fake)         r_revo_fake <= 1'b1;
            else if (w_qual[0]) r_revo_fake <= 1'b0;
            // Counter saturates at the last period value when fakes are disabled.
            if (w_trg[0])                            r_period <= '0;
            else if (r_armed && r_period != PER_LAST) r_period <= r_period + PER_W'(1);
        end
    end

    assign bus.trg_out    = r_trg_out;
    assign bus.encoded_ce = r_ce;
    assign bus.frame_busy = r_busy;
    assign bus.overflow   = r_overflow;
    assign bus.revo_fake  = r_revo_fake;
endmodule

// File: tb/tb_revo_trigger_encoder.sv
// Bench for revo_trigger_encoder: directed table, corner-case sequences and
// randomized pulses compared with a sample-history / frame-queue reference model.
`timescale 1ns/1ps
module tb_revo_trigger_encoder;
    localparam int unsigned CH   = 4;
    localparam int unsigned HIST = 16;
    localparam int unsigned MAXD = 8;
    localparam int unsigned GAPC = 2;
    localparam int unsigned PER  = 64;
    localparam int          CHB  = 2;
    localparam int          NTBL = 37;

    logic clock = 1'b0;
    logic reset = 1'b1;

    revo_trigger_encoder_if #(.CHANNELS(CH)) bus ();

    revo_trigger_encoder #(
        .CHANNELS(CH), .HISTORY(HIST), .MAX_DURATION(MAXD), .GAP(GAPC), .REVO_PERIOD(PER)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [CH-1:0] raw;
        logic [CH-1:0] trg;
        logic          ce;
        logic          busy;
    } vec_t;

    vec_t tbl [NTBL];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    logic [CH-1:0] samp [$];
    logic [1:0]    m_q  [$];
    logic [CH-1:0] m_pend, m_trg;
    logic [1:0]    m_out;
    logic          m_ovf, m_armed, m_fake;
    int            m_last0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit s_at(input int ch, input int e);
        logic [CH-1:0] v;
        if (e < 1 || e > samp.size()) return 1'b0;
        v = samp[e-1];
        return v[ch];
    endfunction

    task automatic model_reset();
        samp.delete();
        m_q.delete();
        m_pend  = '0;
        m_trg   = '0;
        m_out   = 2'b10;
        m_ovf   = 1'b0;
        m_armed = 1'b0;
        m_fake  = 1'b0;
        m_last0 = 0;
        cyc     = 0;
    endtask

    // One clock edge of the specification's behaviour, indexed by edge number n.
    task automatic model_edge(input logic [CH-1:0] raw, input logic fen);
        logic [CH-1:0] qual, clr;
        bit quiet, allone, fake;
        int n, sel;
        samp.push_back(raw);
        n = samp.size();
        qual = '0;
        for (int c = 0; c < int'(CH); c++) begin
            quiet  = 1'b1;
            allone = 1'b1;
            for (int k = int'(MAXD) + 1; k <= int'(HIST); k++) if (s_at(c, n - k)) quiet = 1'b0;
            for (int k = 1; k <= int'(MAXD); k++) if (!s_at(c, n - k)) allone = 1'b0;
            qual[c] = s_at(c, n - int'(MAXD)) && quiet && !allone;
        end
        fake  = m_armed && fen && (n - m_last0 >= int'(PER)) && !qual[0];
        m_trg = qual;
        if (fake) m_trg[0] = 1'b1;
        if (qual[0]) m_armed = 1'b1;
        if (m_trg[0]) m_last0 = n;
        if (fake) m_fake = 1'b1;
        else if (qual[0]) m_fake = 1'b0;
        clr = '0;
        if (m_q.size() == 0 && m_pend != '0) begin
            sel = 0;
            for (int c = int'(CH) - 1; c >= 0; c--) if (m_pend[c]) sel = c;
            clr[sel] = 1'b1;
            m_q.push_back(2'b01);
            for (int b = CHB - 1; b >= 0; b--) m_q.push_back({~sel[b], 1'b1});
            for (int g = 0; g < int'(GAPC); g++) m_q.push_back(2'b11);
            m_q.push_back(2'b10);
        end
        m_out  = (m_q.size() > 0) ? m_q.pop_front() : 2'b10;
        m_ovf  = m_ovf | (|(m_trg & m_pend & ~clr));
        m_pend = (m_pend & ~clr) | m_trg;
    endtask

    task automatic step(input logic [CH-1:0] raw, input logic fen);
        bus.raw_trg     = raw;
        bus.fake_enable = fen;
        @(posedge clock);
        #1;
        cyc++;
        model_edge(raw, fen);
        chk("trg_out",    32'(bus.trg_out),    32'(m_trg));
        chk("encoded_ce", 32'(bus.encoded_ce), 32'(m_out[1]));
        chk("frame_busy", 32'(bus.frame_busy), 32'(m_out[0]));
        chk("overflow",   32'(bus.overflow),   32'(m_ovf));
        chk("revo_fake",  32'(bus.revo_fake),  32'(m_fake));
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.raw_trg     = '0;
        bus.fake_enable = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        chk("rst_trg_out",  32'(bus.trg_out),    0);
        chk("rst_ce",       32'(bus.encoded_ce), 1);
        chk("rst_busy",     32'(bus.frame_busy), 0);
        chk("rst_overflow", 32'(bus.overflow),   0);
        chk("rst_revo_fake",32'(bus.revo_fake),  0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, t_real;
        int rem [CH];
        logic [CH-1:0] raw;
        logic fen;

        bus.raw_trg     = '0;
        bus.fake_enable = 1'b0;

        // Single pulse on ch2, then simultaneous ch0+ch3 pulses.
        for (int i = 0; i < NTBL; i++) tbl[i] = '{raw: '0, trg: '0, ce: 1'b1, busy: 1'b0};
        for (int i = 0; i < 3; i++) tbl[i].raw = 4'b0100;
        tbl[8].trg = 4'b0100;
        tbl[9].ce  = 1'b0;
        tbl[10].ce = 1'b0;
        for (int i = 9; i <= 13; i++) tbl[i].busy = 1'b1;
        tbl[16].raw = 4'b1001;
        tbl[17].raw = 4'b1001;
        tbl[24].trg = 4'b1001;
        tbl[25].ce  = 1'b0;
        tbl[31].ce  = 1'b0;
        tbl[32].ce  = 1'b0;
        tbl[33].ce  = 1'b0;
        for (int i = 25; i <= 29; i++) tbl[i].busy = 1'b1;
        for (int i = 31; i <= 35; i++) tbl[i].busy = 1'b1;

        do_reset();
        for (int i = 0; i < NTBL; i++) begin
            step(tbl[i].raw, 1'b0);
            chk("tbl_trg",  32'(bus.trg_out),    32'(tbl[i].trg));
            chk("tbl_ce",   32'(bus.encoded_ce), 32'(tbl[i].ce));
            chk("tbl_busy", 32'(bus.frame_busy), 32'(tbl[i].busy));
            chk("tbl_ovf",  32'(bus.overflow),   0);
        end

        // Width reject: full-window pulse never qualifies.
        do_reset();
        for (int i = 0; i < 8; i++) step(4'b0010, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(4'b0000, 1'b0);
            chk("reject_wide_trg", 32'(bus.trg_out), 0);
            chk("reject_wide_ce",  32'(bus.encoded_ce), 1);
        end
        // Second pulse too close behind the first is dropped.
        cnt = 0;
        for (int i = 0; i < 38; i++) begin
            raw = (i < 2 || (i >= 6 && i < 8)) ? 4'b0010 : 4'b0000;
            step(raw, 1'b0);
            if (bus.trg_out[1]) cnt++;
        end
        chk("reject_close_count", cnt, 1);

        // Overflow: ch0 hogs the encoder so ch1 retriggers while still pending.
        do_reset();
        for (int i = 0; i < 220; i++) begin
            raw    = '0;
            raw[0] = (i % 9 == 0);
            raw[1] = (i % 10 == 0) || (i % 10 == 1);
            step(raw, 1'b0);
        end
        for (int i = 0; i < 30; i++) step(4'b0000, 1'b0);
        chk("overflow_sticky", 32'(bus.overflow), 1);

        // Fake revo: real ch0 at edge 9, then fakes at +64 and +128.
        do_reset();
        step(4'b0001, 1'b1);
        t_real = cyc + int'(MAXD);
        while (cyc < t_real) step(4'b0000, 1'b1);
        chk("real_ch0", 32'(bus.trg_out[0]), 1);
        for (int k = 1; k <= 2; k++) begin
            while (cyc < t_real + k * int'(PER)) step(4'b0000, 1'b1);
            chk("fake_trg", 32'(bus.trg_out[0]), 1);
            chk("fake_flag", 32'(bus.revo_fake), 1);
        end
        step(4'b0001, 1'b1);
        t_real = cyc + int'(MAXD);
        while (cyc < t_real) step(4'b0000, 1'b1);
        chk("real_after_fake_trg", 32'(bus.trg_out[0]), 1);
        chk("real_clears_fake", 32'(bus.revo_fake), 0);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step(4'b0000, 1'b0);
            if (bus.trg_out[0]) cnt++;
        end
        chk("no_fake_when_disabled", cnt, 0);

        // Reset during the channel bits aborts the frame at once.
        do_reset();
        step(4'b1000, 1'b0);
        while (cyc < 11) step(4'b0000, 1'b0);
        chk("midframe_ce", 32'(bus.encoded_ce), 0);
        chk("midframe_busy", 32'(bus.frame_busy), 1);
        reset = 1'b1;
        #1;
        chk("abort_ce", 32'(bus.encoded_ce), 1);
        chk("abort_busy", 32'(bus.frame_busy), 0);
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step(4'b0000, 1'b0);
            chk("post_abort_ce", 32'(bus.encoded_ce), 1);
        end

        // Randomized pulses of mixed widths and fake_enable toggling.
        do_reset();
        for (int c = 0; c < int'(CH); c++) rem[c] = 0;
        fen = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            raw = '0;
            for (int c = 0; c < int'(CH); c++) begin
                if (rem[c] == 0 && $urandom_range(0, 99) < ((c == 0) ? 2 : 4))
                    rem[c] = int'($urandom_range(1, 10));
                if (rem[c] > 0) begin
                    raw[c] = 1'b1;
                    rem[c]--;
                end
            end
            if ($urandom_range(0, 199) == 0) fen = ~fen;
            step(raw, fen);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
